writeback_register_file: RTL and testbench

WRITEBACK_REGISTER_FILE -- requirements
Module: writeback_register_file

---
 rtl/writeback_register_file.sv | 158 +++++++++++++++
 tb/tb_writeback_register_file.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_register_file.sv
// -----------------------------------------------------------------------------
// writeback_register_file
//
// Purpose
//   32 x 32-bit integer register file sitting between the MEM/WB writeback
//   stage and the decode stage. It selects the writeback value (memory load
//   data or ALU result), commits it on the rising clock edge and serves two
//   zero-latency decode read ports. A read port that addresses the register
//   being written in the same cycle sees the new value (write-first bypass).
//   A separate debug read port shows only committed state. A 32-bit counter
//   records how many register writes have been committed.
//
//   Register 0 is hard-wired to zero. It is never written, never bypassed and
//   never counted.
//
// Ports
//   clock                        rising-edge clock for all state
//   resetN                       asynchronous active-low reset; clears all
//                                registers and the counter immediately
//   wb_shouldWriteRegister       writeback enable
//   wb_registerWriteAddress[4:0] destination register index
//   wb_shouldWriteMemoryElseAluOutputToRegister
//                                1 = wb_memoryData, 0 = wb_aluOutput
//   wb_memoryData[31:0]          load result
//   wb_aluOutput[31:0]           ALU result
//   id_readAddressA/B[4:0]       decode read indices
//   id_readDataA/B[31:0]         decode read data (combinational, bypassed)
//   wb_writeData[31:0]           selected writeback value, for forwarding
//   debugAddress[4:0]            debug read index
//   debugData[31:0]              committed contents at debugAddress
//   retiredWriteCount[31:0]      number of committed writes (wraps)
//
// Interface contract
//   There is no valid/ready handshake on this block. A write is offered by
//   holding wb_shouldWriteRegister high with a non-zero address, and it is
//   always accepted on the next rising edge unless resetN is low at that
//   edge. The select and data inputs are don't-care while the enable is low.
// -----------------------------------------------------------------------------
module writeback_register_file (
  input  logic        clock,
  input  logic        resetN,
  input  logic        wb_shouldWriteRegister,
  input  logic [4:0]  wb_registerWriteAddress,
  input  logic        wb_shouldWriteMemoryElseAluOutputToRegister,
  input  logic [31:0] wb_memoryData,
  input  logic [31:0] wb_aluOutput,
  input  logic [4:0]  id_readAddressA,
  input  logic [4:0]  id_readAddressB,
  output logic [31:0] id_readDataA,
  output logic [31:0] id_readDataB,
  output logic [31:0] wb_writeData,
  input  logic [4:0]  debugAddress,
  output logic [31:0] debugData,
  output logic [31:0] retiredWriteCount
);

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned DATA_W   = 32;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  logic [DATA_W-1:0] retired_count_q;
  logic [DATA_W-1:0] retired_count_d;

  logic              write_en;
  logic [DATA_W-1:0] write_data;

  // The writeback mux is not gated by reset. Forwarding paths elsewhere in
  // the pipeline may look at it while this block is held in reset.
  always_comb begin
    write_data = wb_aluOutput;
    if (wb_shouldWriteMemoryElseAluOutputToRegister) begin
      write_data = wb_memoryData;
    end
  end

  assign wb_writeData = write_data;

  // Effective write. resetN is part of the term so that bypass is also
  // suppressed while reset is low, and not only the commit.
  always_comb begin
    write_en = 1'b0;
    if (resetN && wb_shouldWriteRegister && (wb_registerWriteAddress != 5'd0)) begin
      write_en = 1'b1;
    end
  end

  // Next-state for the array. Only the addressed entry changes. Entry 0 is
  // forced to zero so that it stays constant even if the enable logic is
  // changed later.
  always_comb begin
    regs_d = regs_q;
    if (write_en) begin
      regs_d[wb_registerWriteAddress] = write_data;
    end
    regs_d[0] = '0;
  end

  always_comb begin
    retired_count_d = retired_count_q;
    if (write_en) begin
      // Natural 32-bit wrap from 0xFFFFFFFF back to 0.
      retired_count_d = retired_count_q + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      retired_count_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      retired_count_q <= retired_count_d;
    end
  end

  // Decode read port A: write-first bypass of the in-flight write.
  always_comb begin
    id_readDataA = '0;
    if (resetN && (id_readAddressA != 5'd0)) begin
      if (write_en && (id_readAddressA == wb_registerWriteAddress)) begin
        id_readDataA = write_data;
      end else begin
        id_readDataA = regs_q[id_readAddressA];
      end
    end
  end

  // Decode read port B: the bypass works the same way as on port A and does
  // not depend on it.
  always_comb begin
    id_readDataB = '0;
    if (resetN && (id_readAddressB != 5'd0)) begin
      if (write_en && (id_readAddressB == wb_registerWriteAddress)) begin
        id_readDataB = write_data;
      end else begin
        id_readDataB = regs_q[id_readAddressB];
      end
    end
  end

  // The debug port shows committed state only, with no bypass, so it shows
  // the value from before a write until the clock edge that commits it.
  always_comb begin
    debugData = '0;
    if (resetN && (debugAddress != 5'd0)) begin
      debugData = regs_q[debugAddress];
    end
  end

  assign retiredWriteCount = retired_count_q;

endmodule

// File: tb/tb_writeback_register_file.sv
// -----------------------------------------------------------------------------
// tb_writeback_register_file
//
// Directed bench for writeback_register_file. The driver applies one input
// vector per cycle, #1 after the rising edge. It pushes the hand-computed
// expected outputs for that vector into exp_q. The monitor pops one entry on
// each falling edge and compares every output against it.
// -----------------------------------------------------------------------------
module tb_writeback_register_file;

  // ---------------------------------------------------------------- clock/reset
  logic clock;
  logic resetN;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------------------------------------------------------- DUT
  logic        wb_shouldWriteRegister;
  logic [4:0]  wb_registerWriteAddress;
  logic        wb_shouldWriteMemoryElseAluOutputToRegister;
  logic [31:0] wb_memoryData;
  logic [31:0] wb_aluOutput;
  logic [4:0]  id_readAddressA;
  logic [4:0]  id_readAddressB;
  logic [31:0] id_readDataA;
  logic [31:0] id_readDataB;
  logic [31:0] wb_writeData;
  logic [4:0]  debugAddress;
  logic [31:0] debugData;
  logic [31:0] retiredWriteCount;

  writeback_register_file dut (
    .clock                                       (clock),
    .resetN                                      (resetN),
    .wb_shouldWriteRegister                      (wb_shouldWriteRegister),
    .wb_registerWriteAddress                     (wb_registerWriteAddress),
    .wb_shouldWriteMemoryElseAluOutputToRegister (wb_shouldWriteMemoryElseAluOutputToRegister),
    .wb_memoryData                               (wb_memoryData),
    .wb_aluOutput                                (wb_aluOutput),
    .id_readAddressA                             (id_readAddressA),
    .id_readAddressB                             (id_readAddressB),
    .id_readDataA                                (id_readDataA),
    .id_readDataB                                (id_readDataB),
    .wb_writeData                                (wb_writeData),
    .debugAddress                                (debugAddress),
    .debugData                                   (debugData),
    .retiredWriteCount                           (retiredWriteCount)
  );

  // ---------------------------------------------------------------- scoreboard
  // Entry layout: {readA, readB, debug, writeData, count}
  logic [159:0] exp_q[$];
  int           id_q[$];
  int           checks   = 0;
  int           failures = 0;
  int           vec_id   = 0;

  task automatic check32(input string name, input int id,
                         input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL vec%0d %s: got 0x%08h expected 0x%08h", id, name, act, exp);
    end
  endtask

  // Monitor: the outputs settle between edges, so sample on the falling edge.
  always @(negedge clock) begin
    logic [159:0] e;
    int           id;
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      id = id_q.pop_front();
      check32("readA",     id, id_readDataA,      e[159:128]);
      check32("readB",     id, id_readDataB,      e[127:96]);
      check32("debug",     id, debugData,         e[95:64]);
      check32("writeData", id, wb_writeData,      e[63:32]);
      check32("count",     id, retiredWriteCount, e[31:0]);
    end
  end

  // ---------------------------------------------------------------- driver
  task automatic drive(input logic we, input logic [4:0] wa, input logic sel,
                       input logic [31:0] mem, input logic [31:0] alu,
                       input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] dbg);
    wb_shouldWriteRegister                      = we;
    wb_registerWriteAddress                     = wa;
    wb_shouldWriteMemoryElseAluOutputToRegister = sel;
    wb_memoryData                               = mem;
    wb_aluOutput                                = alu;
    id_readAddressA                             = ra;
    id_readAddressB                             = rb;
    debugAddress                                = dbg;
  endtask

  task automatic push_exp(input logic [31:0] ea, input logic [31:0] eb,
                          input logic [31:0] ed, input logic [31:0] ew,
                          input logic [31:0] ec);
    exp_q.push_back({ea, eb, ed, ew, ec});
    id_q.push_back(vec_id);
    vec_id++;
  endtask

  // One vector per cycle: drive after the rising edge, checked at the next
  // falling edge, committed at the rising edge after that.
  task automatic step(input logic we, input logic [4:0] wa, input logic sel,
                      input logic [31:0] mem, input logic [31:0] alu,
                      input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] dbg,
                      input logic [31:0] ea, input logic [31:0] eb,
                      input logic [31:0] ed, input logic [31:0] ew,
                      input logic [31:0] ec);
    @(posedge clock);
    #1;
    drive(we, wa, sel, mem, alu, ra, rb, dbg);
    push_exp(ea, eb, ed, ew, ec);
  endtask

  function automatic logic [31:0] loop_val(input int i);
    return 32'hC0DE0000 | 32'(i);
  endfunction

  logic [31:0] prior [32];

  // ---------------------------------------------------------------- stimulus
  initial begin
    resetN = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);

    // Held in reset: no bypass, reads are 0, the writeback mux is still live.
    step(1'b1, 5'd5, 1'b0, 32'h0, 32'hDEADBEEF, 5'd5, 5'd0, 5'd5,
         32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 32'd0);
    // Release between edges, with the write still offered. The first rising
    // edge after release commits it.
    @(negedge clock);
    #1 resetN = 1'b1;

    // Readback of r5.
    step(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd5, 5'd0, 5'd5,
         32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0, 32'd1);

    // Select mux: memory data to r3, then ALU output to r4.
    step(1'b1, 5'd3, 1'b1, 32'hAAAA0000, 32'h0000BBBB, 5'd3, 5'd4, 5'd3,
         32'hAAAA0000, 32'h0, 32'h0, 32'hAAAA0000, 32'd1);
    step(1'b1, 5'd4, 1'b0, 32'hAAAA0000, 32'h0000BBBB, 5'd3, 5'd4, 5'd4,
         32'hAAAA0000, 32'h0000BBBB, 32'h0, 32'h0000BBBB, 32'd2);
    step(1'b0, 5'd0, 1'b1, 32'hAAAA0000, 32'h0000BBBB, 5'd3, 5'd4, 5'd4,
         32'hAAAA0000, 32'h0000BBBB, 32'h0000BBBB, 32'hAAAA0000, 32'd3);

    // Bypass: preload r7, then overwrite it while both ports and debug read r7.
    step(1'b1, 5'd7, 1'b0, 32'h0, 32'h11111111, 5'd0, 5'd0, 5'd7,
         32'h0, 32'h0, 32'h0, 32'h11111111, 32'd3);
    step(1'b1, 5'd7, 1'b1, 32'h22222222, 32'h33333333, 5'd7, 5'd7, 5'd7,
         32'h22222222, 32'h22222222, 32'h11111111, 32'h22222222, 32'd4);
    step(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd7, 5'd5, 5'd7,
         32'h22222222, 32'hDEADBEEF, 32'h22222222, 32'h0, 32'd5);

    // r0: the write is ignored, not bypassed and not counted.
    step(1'b1, 5'd0, 1'b0, 32'h0, 32'h12345678, 5'd0, 5'd0, 5'd0,
         32'h0, 32'h0, 32'h0, 32'h12345678, 32'd5);
    step(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd0,
         32'h0, 32'h22222222, 32'h0, 32'h0, 32'd5);

    // Enable low: the address and data are ignored.
    step(1'b0, 5'd9, 1'b1, 32'hFFFFFFFF, 32'h0, 5'd9, 5'd9, 5'd9,
         32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'd5);
    step(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd9, 5'd9, 5'd9,
         32'h0, 32'h0, 32'h0, 32'h0, 32'd5);

    // Port A bypasses while port B reads stored r3.
    step(1'b1, 5'd5, 1'b0, 32'h0, 32'h55555555, 5'd5, 5'd3, 5'd5,
         32'h55555555, 32'hAAAA0000, 32'hDEADBEEF, 32'h55555555, 32'd5);

    // Fill r1..r31. Odd registers take memory data and even ones take ALU
    // output, and the source that is not selected carries the inverse value.
    for (int i = 0; i < 32; i++) prior[i] = 32'h0;
    prior[3] = 32'hAAAA0000;
    prior[4] = 32'h0000BBBB;
    prior[5] = 32'h55555555;
    prior[7] = 32'h22222222;
    for (int i = 1; i < 32; i++) begin
      logic        sel;
      logic [31:0] v;
      sel = (i % 2) == 1;
      v   = loop_val(i);
      step(1'b1, 5'(i), sel, sel ? v : ~v, sel ? ~v : v, 5'(i), 5'(i - 1), 5'(i),
           v, (i == 1) ? 32'h0 : loop_val(i - 1), prior[i], v, 32'(5 + i));
    end
    step(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd31, 5'd1, 5'd17,
         loop_val(31), loop_val(1), loop_val(17), 32'h0, 32'd37);

    // Async reset between edges, while a write to r9 is pending.
    @(posedge clock);
    #1 drive(1'b1, 5'd9, 1'b0, 32'h0, 32'h99999999, 5'd9, 5'd31, 5'd1);
    #2 resetN = 1'b0;
    push_exp(32'h0, 32'h0, 32'h0, 32'h99999999, 32'd0);
    // Still in reset across an edge: the write is ignored.
    step(1'b1, 5'd9, 1'b0, 32'h0, 32'h99999999, 5'd9, 5'd1, 5'd9,
         32'h0, 32'h0, 32'h0, 32'h99999999, 32'd0);
    @(negedge clock);
    #1 drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd9, 5'd1, 5'd31);
    resetN = 1'b1;
    step(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd9, 5'd1, 5'd31,
         32'h0, 32'h0, 32'h0, 32'h0, 32'd0);
    step(1'b1, 5'd2, 1'b0, 32'h0, 32'hBEEF0002, 5'd2, 5'd2, 5'd2,
         32'hBEEF0002, 32'hBEEF0002, 32'h0, 32'hBEEF0002, 32'd0);
    step(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd2, 5'd9, 5'd2,
         32'hBEEF0002, 32'h0, 32'hBEEF0002, 32'h0, 32'd1);

    // Counter wrap: preload the count through a backdoor, then one write.
    @(negedge clock);
    #1 force dut.retired_count_q = 32'hFFFFFFFF;
    #1 release dut.retired_count_q;
    step(1'b1, 5'd6, 1'b0, 32'h0, 32'h66666666, 5'd6, 5'd0, 5'd6,
         32'h66666666, 32'h0, 32'h0, 32'h66666666, 32'hFFFFFFFF);
    step(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd6, 5'd2, 5'd6,
         32'h66666666, 32'hBEEF0002, 32'h66666666, 32'h0, 32'd0);
    step(1'b1, 5'd8, 1'b1, 32'h88888888, 32'h0, 5'd8, 5'd6, 5'd8,
         32'h88888888, 32'h66666666, 32'h0, 32'h88888888, 32'd0);
    step(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd8, 5'd0, 5'd8,
         32'h88888888, 32'h0, 32'h88888888, 32'h0, 32'd1);

    // Drain the scoreboard, with a bound.
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
